// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port DataMemory: CPU first,
// with a starvation guard that lets the debug/DMA port win after a wait.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ACC_CYCLES   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_INIT = CW'(ACC_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic busy, done, grant, grant_dbg, last;

    assign busy      = (state_q == S_BUSY);
    assign done      = (state_q == S_DONE);
    assign grant     = (state_q == S_IDLE) & (cpu_req | dbg_req);
    // dbg wins a tie only once it has waited long enough
    assign grant_dbg = grant & dbg_req
                     & (~cpu_req | (wait_q >= WAIT_MAX));
    assign last      = busy & (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = S_BUSY;
                    owner_d = grant_dbg;
                    we_d    = grant_dbg ? dbg_we    : cpu_we;
                    addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
                    wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
                    cnt_d   = CNT_INIT;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        if (last && !we_q) begin
            if (owner_q) dbg_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (grant_dbg)
            wait_d = '0;
        else if (dbg_req && (wait_q < WAIT_MAX))
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // strobes derive from state only, so reset drops mem_wr at once
    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign mem_rd    = busy & ~we_q;
    assign mem_wr    = busy &  we_q;

    assign cpu_ack   = done & ~owner_q;
    assign dbg_ack   = done &  owner_q;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance A uses ACC_CYCLES=1,
// instance B uses ACC_CYCLES=3; each has its own small memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic        cpu_req_a, cpu_we_a, dbg_req_a, dbg_we_a;
    logic [31:0] cpu_addr_a, cpu_wdata_a, dbg_addr_a, dbg_wdata_a;
    logic [31:0] cpu_rdata_a, dbg_rdata_a, mem_addr_a, mem_wdata_a;
    logic [31:0] mem_rdata_a;
    logic        cpu_ack_a, cpu_stall_a, dbg_ack_a, mem_rd_a, mem_wr_a;

    logic        cpu_req_b, cpu_we_b, dbg_req_b, dbg_we_b;
    logic [31:0] cpu_addr_b, cpu_wdata_b, dbg_addr_b, dbg_wdata_b;
    logic [31:0] cpu_rdata_b, dbg_rdata_b, mem_addr_b, mem_wdata_b;
    logic [31:0] mem_rdata_b;
    logic        cpu_ack_b, cpu_stall_b, dbg_ack_b, mem_rd_b, mem_wr_b;

    dmem_arbiter #(.ACC_CYCLES(1), .STARVE_LIMIT(4)) u_a (
        .clk(clk), .Reset(rst_n),
        .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a),
        .cpu_wdata(cpu_wdata_a), .cpu_rdata(cpu_rdata_a),
        .cpu_ack(cpu_ack_a), .cpu_stall(cpu_stall_a),
        .dbg_req(dbg_req_a), .dbg_we(dbg_we_a), .dbg_addr(dbg_addr_a),
        .dbg_wdata(dbg_wdata_a), .dbg_rdata(dbg_rdata_a),
        .dbg_ack(dbg_ack_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rd(mem_rd_a), .mem_wr(mem_wr_a), .mem_rdata(mem_rdata_a)
    );

    dmem_arbiter #(.ACC_CYCLES(3), .STARVE_LIMIT(4)) u_b (
        .clk(clk), .Reset(rst_n),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b),
        .cpu_wdata(cpu_wdata_b), .cpu_rdata(cpu_rdata_b),
        .cpu_ack(cpu_ack_b), .cpu_stall(cpu_stall_b),
        .dbg_req(dbg_req_b), .dbg_we(dbg_we_b), .dbg_addr(dbg_addr_b),
        .dbg_wdata(dbg_wdata_b), .dbg_rdata(dbg_rdata_b),
        .dbg_ack(dbg_ack_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_rdata(mem_rdata_b)
    );

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    int wr_cnt_b = 0;

    assign mem_rdata_a = mem_a[mem_addr_a[7:2]];
    assign mem_rdata_b = mem_b[mem_addr_b[7:2]];

    always @(posedge clk) begin
        if (mem_wr_a) mem_a[mem_addr_a[7:2]] <= mem_wdata_a;
        if (mem_wr_b) begin
            mem_b[mem_addr_b[7:2]] <= mem_wdata_b;
            wr_cnt_b++;
        end
    end

    always @(negedge clk) begin
        chk("rdwr_excl_a", {31'b0, mem_rd_a & mem_wr_a}, 32'd0);
        chk("ack_excl_a",  {31'b0, cpu_ack_a & dbg_ack_a}, 32'd0);
        chk("rdwr_excl_b", {31'b0, mem_rd_b & mem_wr_b}, 32'd0);
        chk("ack_excl_b",  {31'b0, cpu_ack_b & dbg_ack_b}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          wr_cycles, rd_cycles, acks, n_acks, snap_cnt;
    bit          seen;
    logic [1:0]  ack_seq [0:7];
    logic [31:0] snap_mem;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[4]  = 32'hDEADBEEF;
        mem_a[12] = 32'hCAFEF00D;
        mem_b[8]  = 32'hAAAA5555;
        mem_b[9]  = 32'h0BADF00D;
        cpu_req_a = 1'b1; cpu_we_a = 1'b0;
        cpu_addr_a = 32'h10; cpu_wdata_a = '0;
        dbg_req_a = 1'b1; dbg_we_a = 1'b0;
        dbg_addr_a = 32'h30; dbg_wdata_a = '0;
        cpu_req_b = 1'b0; cpu_we_b = 1'b0;
        cpu_addr_b = '0; cpu_wdata_b = '0;
        dbg_req_b = 1'b0; dbg_we_b = 1'b0;
        dbg_addr_b = '0; dbg_wdata_b = '0;

        // reset held with both requests high
        tick();
        tick();
        chk("rst_mem_rd",   {31'b0, mem_rd_a}, 32'd0);
        chk("rst_mem_wr",   {31'b0, mem_wr_a}, 32'd0);
        chk("rst_cpu_ack",  {31'b0, cpu_ack_a}, 32'd0);
        chk("rst_dbg_ack",  {31'b0, dbg_ack_a}, 32'd0);
        chk("rst_cpu_rdat", cpu_rdata_a, 32'd0);
        chk("rst_dbg_rdat", dbg_rdata_a, 32'd0);
        chk("rst_mem_addr", mem_addr_a, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t1_grant_rd",   {31'b0, mem_rd_a}, 32'd1);
        chk("t1_grant_addr", mem_addr_a, 32'h10);
        tick();
        chk("t1_cpu_ack",    {31'b0, cpu_ack_a}, 32'd1);
        chk("t1_dbg_ack",    {31'b0, dbg_ack_a}, 32'd0);
        chk("t1_cpu_rdata",  cpu_rdata_a, 32'hDEADBEEF);
        cpu_req_a = 1'b0;
        dbg_req_a = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t1_rst_rdata",  cpu_rdata_a, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single CPU read, one-cycle access
        cpu_req_a = 1'b1;
        tick();
        chk("t2_mem_rd",    {31'b0, mem_rd_a}, 32'd1);
        chk("t2_mem_wr",    {31'b0, mem_wr_a}, 32'd0);
        chk("t2_mem_addr",  mem_addr_a, 32'h10);
        chk("t2_ack_early", {31'b0, cpu_ack_a}, 32'd0);
        chk("t2_stall_hi",  {31'b0, cpu_stall_a}, 32'd1);
        tick();
        chk("t2_mem_rd_off", {31'b0, mem_rd_a}, 32'd0);
        chk("t2_cpu_ack",    {31'b0, cpu_ack_a}, 32'd1);
        chk("t2_cpu_rdata",  cpu_rdata_a, 32'hDEADBEEF);
        chk("t2_stall_lo",   {31'b0, cpu_stall_a}, 32'd0);
        chk("t2_addr_zero",  mem_addr_a, 32'd0);
        cpu_req_a = 1'b0;
        tick();
        chk("t2_ack_pulse",  {31'b0, cpu_ack_a}, 32'd0);
        chk("t2_rdata_hold", cpu_rdata_a, 32'hDEADBEEF);

        // dbg read then dbg write, three-cycle access
        dbg_req_b = 1'b1; dbg_we_b = 1'b0; dbg_addr_b = 32'h20;
        rd_cycles = 0; seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (mem_rd_b) rd_cycles++;
            if (dbg_ack_b) begin
                seen = 1'b1;
                dbg_req_b = 1'b0;
            end
        end
        chk("t3_rd_ack_seen", {31'b0, seen}, 32'd1);
        chk("t3_rd_cycles",   rd_cycles, 32'd3);
        chk("t3_rd_rdata",    dbg_rdata_b, 32'hAAAA5555);
        tick();
        dbg_req_b = 1'b1; dbg_we_b = 1'b1;
        dbg_wdata_b = 32'h12345678;
        wr_cycles = 0; acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_wr_b) wr_cycles++;
            if (cpu_ack_b) acks += 100;
            if (dbg_ack_b) begin
                acks++;
                dbg_req_b = 1'b0;
            end
        end
        chk("t3_wr_cycles", wr_cycles, 32'd3);
        chk("t3_wr_acks",   acks, 32'd1);
        chk("t3_rdata_kept", dbg_rdata_b, 32'hAAAA5555);
        chk("t3_mem_data",  mem_b[8], 32'h12345678);

        // both requesters held continuously
        cpu_req_a = 1'b1;
        dbg_req_a = 1'b1;
        n_acks = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (cpu_ack_a || dbg_ack_a) begin
                if (n_acks < 8) ack_seq[n_acks] = cpu_ack_a ? 2'd1 : 2'd2;
                n_acks++;
            end
        end
        cpu_req_a = 1'b0;
        dbg_req_a = 1'b0;
        chk("t4_n_acks", n_acks, 32'd5);
        chk("t4_ack0_cpu", {30'b0, ack_seq[0]}, 32'd1);
        chk("t4_ack1_cpu", {30'b0, ack_seq[1]}, 32'd1);
        chk("t4_ack2_dbg", {30'b0, ack_seq[2]}, 32'd2);
        chk("t4_ack3_cpu", {30'b0, ack_seq[3]}, 32'd1);
        chk("t4_ack4_dbg", {30'b0, ack_seq[4]}, 32'd2);
        chk("t4_dbg_rdata", dbg_rdata_a, 32'hCAFEF00D);
        chk("t4_cpu_rdata", cpu_rdata_a, 32'hDEADBEEF);
        tick();

        // reset in the second BUSY cycle of a three-cycle write
        cpu_req_b = 1'b1; cpu_we_b = 1'b1;
        cpu_addr_b = 32'h24; cpu_wdata_b = 32'h55AA55AA;
        tick();
        chk("t5_wr_c1",   {31'b0, mem_wr_b}, 32'd1);
        chk("t5_addr_c1", mem_addr_b, 32'h24);
        tick();
        chk("t5_wr_c2",   {31'b0, mem_wr_b}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_wr_async", {31'b0, mem_wr_b}, 32'd0);
        chk("t5_addr_clr", mem_addr_b, 32'd0);
        chk("t5_rdata_clr", dbg_rdata_b, 32'd0);
        snap_mem = mem_b[9];
        snap_cnt = wr_cnt_b;
        cpu_req_b = 1'b0;
        tick();
        chk("t5_no_ack", {31'b0, cpu_ack_b}, 32'd0);
        tick();
        chk("t5_no_ack2",  {31'b0, cpu_ack_b}, 32'd0);
        chk("t5_mem_same", mem_b[9], snap_mem);
        chk("t5_no_write", wr_cnt_b, snap_cnt);
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_idle_wr", {31'b0, mem_wr_b}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
